control_sequencer: RTL and testbench

Instruction sequencer that consumes the 33-bit control words produced by the per-opcode decoder bank and drives the datapath. It fetches the instruction into the instruction register and feeds it, the micro-state and the registered status flags back to the decoders. It then walks the multi-cycle micro-states named by each control word's next_state field, stalls on slow memory, and returns to fetch when next_state is 00. It sits between the decoder bank and the datapath: ALU, register file, RAM and PC.

---
 rtl/cpu_pkg.sv | 56 +++++
 rtl/control_sequencer_if.sv | 28 ++
 rtl/control_sequencer_stall_watchdog.sv | 21 ++
 rtl/control_sequencer.sv | 90 +++++++++
 tb/tb_control_sequencer.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared control-word layout, fetch/halt words, phase and next_state encodings.
//   Control word (CW_W=33 bits, MSB first):
//     alu_en, alu_bs, alu_fs[4:0], rf_b_en, sa[4:0], sb[4:0], da[4:0],
//     rf_w, ram_en, ram_w, pc_en, pc_fs[1:0], pc_is, status_ld, next_state[1:0]
//   The datapath sees bits [32:2] (31 bits); offsets below are cw_in positions.
//   Stall watchdog feature macro: CTRL_STALL_TIMEOUT_EN.
package cpu_pkg;
    localparam int CW_W    = 33;
    localparam int CWDP_W  = 31;
    localparam int CW_NS        = 0;
    localparam int CW_NS_W      = 2;
    localparam int CW_STATUS_LD = 2;
    localparam int CW_PC_IS     = 3;
    localparam int CW_PC_FS     = 4;
    localparam int CW_PC_FS_W   = 2;
    localparam int CW_PC_EN     = 6;
    localparam int CW_RAM_W     = 7;
    localparam int CW_RAM_EN    = 8;
    localparam int CW_RF_W      = 9;
    localparam int CW_DA        = 10;
    localparam int CW_SB        = 15;
    localparam int CW_SA        = 20;
    localparam int CW_REG_W     = 5;
    localparam int CW_RF_B_EN   = 25;
    localparam int CW_ALU_FS    = 26;
    localparam int CW_ALU_FS_W  = 5;
    localparam int CW_ALU_BS    = 31;
    localparam int CW_ALU_EN    = 32;
    localparam int STATUS_W     = 5;

    typedef logic [1:0] phase_t;
    localparam phase_t PH_FETCH = 2'b00;
    localparam phase_t PH_EXEC  = 2'b01;
    localparam phase_t PH_HALT  = 2'b10;

    typedef logic [CW_NS_W-1:0] next_state_t;
    localparam next_state_t NS_END = 2'b00;

    // Single-bit mask in cw_dp coordinates for a field at cw_in position p.
    function automatic logic [CWDP_W-1:0] dp_bit(input int p);
        return CWDP_W'(1) << (p - CW_NS_W);
    endfunction

    // Fetch word: read RAM at PC onto the bus, every write strobe off, PC held.
    localparam logic [CWDP_W-1:0] FETCH_CW = {
        1'b0, 1'b1, 5'b11111, 1'b0,
        5'd31, 5'd31, 5'd31,
        1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0
    };
    localparam logic [CWDP_W-1:0] HALT_CW = FETCH_CW & ~dp_bit(CW_RAM_EN);

    // Fields forced to zero while a memory access stalls.
    localparam logic [CWDP_W-1:0] GATE_MASK =
        dp_bit(CW_RF_W) | dp_bit(CW_RAM_W) | dp_bit(CW_PC_FS) |
        dp_bit(CW_PC_FS + 1) | dp_bit(CW_STATUS_LD);
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: decoder/datapath bundle around the sequencer.
//   master: sequencer side (consumes cw_in/k_in/status_in/databus/mem_ready,
//           drives ir/state/status/cw_dp/k_out/fetch/halted).
//   slave : decoder bank + datapath side.
interface control_sequencer_if;
    import cpu_pkg::*;
    logic [CW_W-1:0]     cw_in;
    logic [63:0]         k_in;
    logic [STATUS_W-1:0] status_in;
    logic [63:0]         databus;
    logic                mem_ready;
    logic [31:0]         ir;
    logic [1:0]          state;
    logic [STATUS_W-1:0] status;
    logic [CWDP_W-1:0]   cw_dp;
    logic [63:0]         k_out;
    logic                fetch;
    logic                halted;

    modport master (
        input  cw_in, k_in, status_in, databus, mem_ready,
        output ir, state, status, cw_dp, k_out, fetch, halted
    );
    modport slave (
        output cw_in, k_in, status_in, databus, mem_ready,
        input  ir, state, status, cw_dp, k_out, fetch, halted
    );
endinterface

// File: rtl/control_sequencer_stall_watchdog.sv
// stall_watchdog: counts consecutive stalled cycles; flags timeout at 255 with stall still present.
//   clock, reset_n (sync, active-low), stall in; timeout out.
//   Used only when CTRL_STALL_TIMEOUT_EN is defined.
module stall_watchdog (
    input  logic clock,
    input  logic reset_n,
    input  logic stall,
    output logic timeout
);
    logic [7:0] cnt_q, cnt_d;

    // Saturate so a lingering stall never wraps back below the threshold.
    always_comb cnt_d = !stall ? 8'd0 : (cnt_q == 8'hFF ? cnt_q : cnt_q + 8'd1);

    always_ff @(posedge clock) begin
        if (!reset_n) cnt_q <= 8'd0;
        else          cnt_q <= cnt_d;
    end

    assign timeout = stall && cnt_q == 8'hFF;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: FETCH/EXEC/HALT instruction sequencer between decoder bank and datapath.
//   clock, reset_n (sync, active-low); bus: control_sequencer_if.master
//   (cw_in, k_in, status_in, databus, mem_ready in; ir, state, status, cw_dp,
//   k_out, fetch, halted out).
//   CTRL_STALL_TIMEOUT_EN: stall watchdog that moves to HALT after 256 stalled cycles.
module control_sequencer
    import cpu_pkg::*;
(
    input logic                 clock,
    input logic                 reset_n,
    control_sequencer_if.master bus
);
    phase_t              phase_q, phase_d;
    logic [31:0]         ir_q, ir_d;
    logic [1:0]          state_q, state_d;
    logic [STATUS_W-1:0] status_q, status_d;
    logic                exec_stall, stall, timeout;
    logic [CWDP_W-1:0]   cw_word;

    assign cw_word    = bus.cw_in[CW_W-1:CW_NS_W];
    assign exec_stall = phase_q == PH_EXEC && bus.cw_in[CW_RAM_EN] && !bus.mem_ready;
    assign stall      = (phase_q == PH_FETCH && !bus.mem_ready) || exec_stall;

`ifdef CTRL_STALL_TIMEOUT_EN
    stall_watchdog u_watchdog (
        .clock   (clock),
        .reset_n (reset_n),
        .stall   (stall),
        .timeout (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        phase_d  = phase_q;
        ir_d     = ir_q;
        state_d  = state_q;
        status_d = status_q;
        case (phase_q)
            PH_FETCH: begin
                if (bus.mem_ready) begin
                    ir_d    = bus.databus[31:0];
                    state_d = NS_END;
                    phase_d = PH_EXEC;
                end else if (timeout) begin
                    phase_d = PH_HALT;
                end
            end
            PH_EXEC: begin
                if (exec_stall) begin
                    phase_d = timeout ? PH_HALT : PH_EXEC;
                end else begin
                    status_d = bus.cw_in[CW_STATUS_LD] ? bus.status_in : status_q;
                    state_d  = bus.cw_in[CW_NS +: CW_NS_W];
                    phase_d  = bus.cw_in[CW_NS +: CW_NS_W] == NS_END ? PH_FETCH : PH_EXEC;
                end
            end
            PH_HALT: phase_d = PH_HALT;
            default: phase_d = PH_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            phase_q  <= PH_FETCH;
            ir_q     <= 32'd0;
            state_q  <= NS_END;
            status_q <= '0;
        end else begin
            phase_q  <= phase_d;
            ir_q     <= ir_d;
            state_q  <= state_d;
            status_q <= status_d;
        end
    end

    assign bus.cw_dp  = phase_q == PH_EXEC ? (exec_stall ? cw_word & ~GATE_MASK : cw_word)
                      : phase_q == PH_HALT ? HALT_CW : FETCH_CW;
    assign bus.k_out  = phase_q == PH_EXEC ? bus.k_in : 64'd0;
    assign bus.fetch  = phase_q == PH_FETCH;
    assign bus.ir     = ir_q;
    assign bus.state  = state_q;
    assign bus.status = status_q;
`ifdef CTRL_STALL_TIMEOUT_EN
    assign bus.halted = phase_q == PH_HALT;
`else
    assign bus.halted = 1'b0;
`endif
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed self-checking bench for control_sequencer.
module tb_control_sequencer;
    logic clock = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;

    localparam logic [30:0] FETCH_WORD = 31'h3F7F_FF40;
    localparam logic [30:0] HALT_WORD  = 31'h3F7F_FF00;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.cw_in     = '0;
        bus.k_in      = 64'h55;
        bus.status_in = '0;
        bus.databus   = '0;
        bus.mem_ready = 1'b0;
        tick();
        tick();
        chk("rst_fetch", 64'(bus.fetch), 64'd1);
        chk("rst_halted", 64'(bus.halted), 64'd0);
        chk("rst_ir", 64'(bus.ir), 64'd0);
        chk("rst_state", 64'(bus.state), 64'd0);
        chk("rst_status", 64'(bus.status), 64'd0);
        chk("rst_cw_dp", 64'(bus.cw_dp), 64'(FETCH_WORD));
        chk("rst_k_out", bus.k_out, 64'd0);

        // first fetch
        reset_n       = 1'b1;
        bus.databus   = 64'hDEAD_BEEF_9400_0003;
        bus.mem_ready = 1'b1;
        tick();
        chk("f1_ir", 64'(bus.ir), 64'h9400_0003);
        chk("f1_fetch", 64'(bus.fetch), 64'd0);
        chk("f1_state", 64'(bus.state), 64'd0);

        // branch-and-link: da=30, rf_w=1, pc_en=1, pc_fs=11, next_state 00
        bus.cw_in     = 33'h0_0000_7A70;
        bus.k_in      = 64'd3;
        bus.mem_ready = 1'b0;
        #1;
        chk("bl_cw_dp", 64'(bus.cw_dp), 64'h1E9C);
        chk("bl_k_out", bus.k_out, 64'd3);
        tick();
        chk("bl_fetch", 64'(bus.fetch), 64'd1);
        chk("bl_state", 64'(bus.state), 64'd0);
        chk("bl_k_zero", bus.k_out, 64'd0);

        // fetch stalled for 3 cycles
        bus.databus = 64'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fs_ir", 64'(bus.ir), 64'h9400_0003);
            chk("fs_cw_dp", 64'(bus.cw_dp), 64'(FETCH_WORD));
        end
        bus.mem_ready = 1'b1;
        tick();
        chk("fs_ir_load", 64'(bus.ir), 64'h1234_5678);
        chk("fs_exec", 64'(bus.fetch), 64'd0);

        // EXEC memory stall: alu_en, rf_w, ram_en, ram_w, pc_fs=01, status_ld, next_state 00
        bus.cw_in     = 33'h1_0000_0394;
        bus.status_in = 5'b11111;
        bus.mem_ready = 1'b0;
        #1;
        chk("es_gate0", 64'(bus.cw_dp), 64'h4000_0040);
        tick();
        chk("es_hold_fetch", 64'(bus.fetch), 64'd0);
        chk("es_hold_status", 64'(bus.status), 64'd0);
        chk("es_gate1", 64'(bus.cw_dp), 64'h4000_0040);
        tick();
        chk("es_gate2", 64'(bus.cw_dp), 64'h4000_0040);
        bus.mem_ready = 1'b1;
        #1;
        chk("es_ready_cw", 64'(bus.cw_dp), 64'h4000_00E5);
        tick();
        chk("es_status", 64'(bus.status), 64'h1F);
        chk("es_end_fetch", 64'(bus.fetch), 64'd1);

        // micro-state chain 00 -> 01 -> 10 -> 00
        bus.databus   = 64'hAAAA_5555;
        bus.cw_in     = '0;
        bus.status_in = 5'b10101;
        tick();
        chk("ms_ir", 64'(bus.ir), 64'hAAAA_5555);
        bus.cw_in = 33'h0_0000_0001;
        tick();
        chk("ms_state1", 64'(bus.state), 64'd1);
        chk("ms_exec1", 64'(bus.fetch), 64'd0);
        chk("ms_status_keep", 64'(bus.status), 64'h1F);
        bus.cw_in = 33'h0_0000_0006;
        tick();
        chk("ms_state2", 64'(bus.state), 64'd2);
        chk("ms_status_ld", 64'(bus.status), 64'h15);
        bus.cw_in     = '0;
        bus.status_in = '0;
        tick();
        chk("ms_end_fetch", 64'(bus.fetch), 64'd1);
        chk("ms_end_state", 64'(bus.state), 64'd0);
        chk("ms_status_final", 64'(bus.status), 64'h15);

        // reset in the middle of an instruction: write strobe still visible
        bus.cw_in = 33'h0_0000_0201;
        tick();
        reset_n = 1'b0;
        #1;
        chk("mr_cw_dp", 64'(bus.cw_dp), 64'h80);
        tick();
        chk("mr_fetch", 64'(bus.fetch), 64'd1);
        chk("mr_ir", 64'(bus.ir), 64'd0);
        chk("mr_status", 64'(bus.status), 64'd0);
        chk("mr_state", 64'(bus.state), 64'd0);

        // long fetch stall
        bus.mem_ready = 1'b0;
        bus.cw_in     = '0;
        reset_n       = 1'b1;
`ifdef CTRL_STALL_TIMEOUT_EN
        for (int i = 0; i < 255; i++) tick();
        chk("to_not_yet", 64'(bus.halted), 64'd0);
        chk("to_still_fetch", 64'(bus.fetch), 64'd1);
        tick();
        chk("to_halted", 64'(bus.halted), 64'd1);
        chk("to_halt_cw", 64'(bus.cw_dp), 64'(HALT_WORD));
        chk("to_fetch_low", 64'(bus.fetch), 64'd0);
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("to_stay_halted", 64'(bus.halted), 64'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("to_rst_halted", 64'(bus.halted), 64'd0);
        chk("to_rst_fetch", 64'(bus.fetch), 64'd1);
`else
        for (int i = 0; i < 300; i++) tick();
        chk("ns_no_halt", 64'(bus.halted), 64'd0);
        chk("ns_fetch", 64'(bus.fetch), 64'd1);
        chk("ns_cw_dp", 64'(bus.cw_dp), 64'(FETCH_WORD));
        chk("ns_halt_word_unused", 64'(bus.cw_dp == HALT_WORD), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
